// File: rtl/uart_tx_core.sv
// UART transmit core: one serial bit per CLK, start + DATA_WIDTH data bits (LSB first)
// + optional parity + one stop bit; idle-high line with registered TX_OUT and Busy.
module uart_tx_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Even parity is the XOR of all data bits; odd parity inverts it.
   function automatic logic parity_f(input logic [DATA_WIDTH-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   state_t                 state_r, state_s;
   logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_s;
   logic [DATA_WIDTH-1:0]  data_r, data_s;
   logic                   par_en_r, par_en_s;
   logic                   par_typ_r, par_typ_s;
   logic                   tx_out_r, tx_s;
   logic                   busy_r, busy_s;

   // Next-state, frame-field latching and bit counter sequencing.
   always_comb begin
      state_s   = state_r;
      bit_cnt_s = bit_cnt_r;
      data_s    = data_r;
      par_en_s  = par_en_r;
      par_typ_s = par_typ_r;
      case (state_r)
         IDLE: begin
            bit_cnt_s = {CNT_W{1'b0}};
            if (Data_Valid) begin
               state_s   = START;
               data_s    = P_DATA;
               par_en_s  = PAR_EN;
               par_typ_s = PAR_TYP;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            state_s   = DATA;
            bit_cnt_s = {CNT_W{1'b0}};
         end
         DATA: begin
            if (bit_cnt_r == LAST_BIT) begin
               bit_cnt_s = {CNT_W{1'b0}};
               if (par_en_r) begin
                  state_s = PARITY;
               end else begin
                  state_s = STOP;
               end
            end else begin
               bit_cnt_s = bit_cnt_r + CNT_W'(1'b1);
            end
         end
         PARITY: begin
            state_s   = STOP;
            bit_cnt_s = {CNT_W{1'b0}};
         end
         STOP: begin
            state_s   = IDLE;
            bit_cnt_s = {CNT_W{1'b0}};
         end
         default: begin
            state_s   = IDLE;
            bit_cnt_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so the registers show the current bit.
   always_comb begin
      tx_s   = 1'b1;
      busy_s = 1'b0;
      case (state_s)
         IDLE: begin
            tx_s   = 1'b1;
            busy_s = 1'b0;
         end
         START: begin
            tx_s   = 1'b0;
            busy_s = 1'b1;
         end
         DATA: begin
            tx_s   = data_s[bit_cnt_s];
            busy_s = 1'b1;
         end
         PARITY: begin
            tx_s   = parity_f(data_s, par_typ_s);
            busy_s = 1'b1;
         end
         STOP: begin
            tx_s   = 1'b1;
            busy_s = 1'b1;
         end
         default: begin
            tx_s   = 1'b1;
            busy_s = 1'b0;
         end
      endcase
   end

   // State, latched frame fields and registered line outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r   <= IDLE;
         bit_cnt_r <= {CNT_W{1'b0}};
         data_r    <= {DATA_WIDTH{1'b0}};
         par_en_r  <= 1'b0;
         par_typ_r <= 1'b0;
         tx_out_r  <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         bit_cnt_r <= bit_cnt_s;
         data_r    <= data_s;
         par_en_r  <= par_en_s;
         par_typ_r <= par_typ_s;
         tx_out_r  <= tx_s;
         busy_r    <= busy_s;
      end
   end

   assign TX_OUT = tx_out_r;
   assign Busy   = busy_r;

endmodule
